// File: rtl/llr_data_bank.sv
// LLR storage bank: serial channel load, then per-word overwrite or saturating accumulate from NUM_SRC buses.
// Latency: 1-cycle registered read, flags 1 cycle after the causing write; no backpressure, accepts every cycle.
module llr_data_bank #(
  parameter  int D_WID   = 8,
  parameter  int DEPTH   = 4,
  parameter  int NUM_SRC = 3,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               fsm,
  input  logic                     sin,
  input  logic [D_WID-1:0]         din,
  input  logic [AW-1:0]            waddr,
  input  logic [NUM_SRC-1:0]       vtc_en,
  input  logic [NUM_SRC*D_WID-1:0] dvtc,
  input  logic                     acc_mode,
  input  logic [AW-1:0]            raddr,
  output logic [D_WID-1:0]         ram_d,
  output logic                     rd_vld,
  output logic                     load_done,
  output logic                     sat_flag
);

  localparam logic [AW:0]          DEPTH_L = DEPTH[AW:0];
  localparam logic [AW-1:0]        LAST    = AW'(DEPTH - 1);
  localparam logic signed [D_WID:0] SAT_MAX = (D_WID+1)'((1 << (D_WID-1)) - 1);
  localparam logic signed [D_WID:0] SAT_MIN = -SAT_MAX;

  logic [D_WID-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]        valid;
  logic [AW-1:0]           lptr;

  logic                    load_en;
  logic                    waddr_ok;
  logic                    raddr_ok;
  logic                    upd_en;
  logic [D_WID-1:0]        sel;
  logic [D_WID-1:0]        cur;
  logic signed [D_WID:0]   sum;
  logic [D_WID-1:0]        acc_res;
  logic                    acc_sat;
  logic [D_WID-1:0]        wdata;

  assign load_en  = fsm[1] & sin;
  assign waddr_ok = {1'b0, waddr} < DEPTH_L;
  assign raddr_ok = {1'b0, raddr} < DEPTH_L;
  assign upd_en   = fsm[2] & ~load_en & (|vtc_en) & waddr_ok;
  assign cur      = waddr_ok ? mem[waddr] : '0;

  // Ascending scan so the highest enabled source is the last assignment and wins.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (vtc_en[k]) sel = dvtc[k*D_WID +: D_WID];
    end
  end

  // Symmetric clamp keeps the most negative code out of accumulated results.
  always_comb begin
    sum     = $signed({cur[D_WID-1], cur}) + $signed({sel[D_WID-1], sel});
    acc_res = sum[D_WID-1:0];
    acc_sat = 1'b0;
    if (sum > SAT_MAX) begin
      acc_res = SAT_MAX[D_WID-1:0];
      acc_sat = 1'b1;
    end else if (sum < SAT_MIN) begin
      acc_res = SAT_MIN[D_WID-1:0];
      acc_sat = 1'b1;
    end
  end

  assign wdata = acc_mode ? acc_res : sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid     <= '0;
      lptr      <= '0;
      ram_d     <= '0;
      rd_vld    <= 1'b0;
      load_done <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      sat_flag  <= 1'b0;

      if (!fsm[1]) begin
        lptr <= '0;
      end else if (sin) begin
        mem[lptr]   <= din;
        valid[lptr] <= 1'b1;
        if (lptr == LAST) begin
          lptr      <= '0;
          load_done <= 1'b1;
        end else begin
          lptr <= lptr + AW'(1);
        end
      end

      if (upd_en) begin
        mem[waddr]   <= wdata;
        valid[waddr] <= 1'b1;
        sat_flag     <= acc_mode & acc_sat;
      end

      // Non-blocking read of the pre-edge array gives read-before-write.
      if (raddr_ok) begin
        ram_d  <= mem[raddr];
        rd_vld <= valid[raddr];
      end else begin
        ram_d  <= '0;
        rd_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_llr_data_bank.sv
// Randomized and directed bench for llr_data_bank with a queue-based scoreboard.
module tb_llr_data_bank;

  localparam int D_WID   = 8;
  localparam int DEPTH   = 4;
  localparam int NUM_SRC = 3;
  localparam int AW      = $clog2(DEPTH);

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [3:0]               fsm = '0;
  logic                     sin = 1'b0;
  logic [D_WID-1:0]         din = '0;
  logic [AW-1:0]            waddr = '0;
  logic [NUM_SRC-1:0]       vtc_en = '0;
  logic [NUM_SRC*D_WID-1:0] dvtc = '0;
  logic                     acc_mode = 1'b0;
  logic [AW-1:0]            raddr = '0;
  logic [D_WID-1:0]         ram_d;
  logic                     rd_vld;
  logic                     load_done;
  logic                     sat_flag;

  llr_data_bank #(.D_WID(D_WID), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC)) dut (
    .clk(clk), .reset(reset), .fsm(fsm), .sin(sin), .din(din), .waddr(waddr),
    .vtc_en(vtc_en), .dvtc(dvtc), .acc_mode(acc_mode), .raddr(raddr),
    .ram_d(ram_d), .rd_vld(rd_vld), .load_done(load_done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [D_WID-1:0] d;
    logic             v;
    logic             ld;
    logic             sf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [D_WID-1:0] m_mem [DEPTH];
  logic             m_val [DEPTH];
  int               m_lptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_val[i] = 1'b0;
    end
    m_lptr = 0;
  endtask

  // Reference model: expected registered outputs for the current inputs, then state update.
  task automatic model_step(output exp_t e);
    int ra, wa, s, cv, sum, win;
    ra = int'(raddr);
    wa = int'(waddr);
    e.d  = (ra < DEPTH) ? m_mem[ra] : '0;
    e.v  = (ra < DEPTH) ? m_val[ra] : 1'b0;
    e.ld = 1'b0;
    e.sf = 1'b0;
    if (!fsm[1]) begin
      m_lptr = 0;
    end else if (sin) begin
      m_mem[m_lptr] = din;
      m_val[m_lptr] = 1'b1;
      if (m_lptr == DEPTH - 1) begin
        m_lptr = 0;
        e.ld   = 1'b1;
      end else begin
        m_lptr++;
      end
    end
    if (!(fsm[1] && sin) && fsm[2] && vtc_en != 0 && wa < DEPTH) begin
      win = 0;
      for (int k = 0; k < NUM_SRC; k++) if (vtc_en[k]) win = k;
      s = int'($signed(dvtc[win*D_WID +: D_WID]));
      if (acc_mode) begin
        cv  = int'($signed(m_mem[wa]));
        sum = cv + s;
        if (sum > 127) begin
          sum  = 127;
          e.sf = 1'b1;
        end else if (sum < -127) begin
          sum  = -127;
          e.sf = 1'b1;
        end
        m_mem[wa] = 8'(sum);
      end else begin
        m_mem[wa] = 8'(s);
      end
      m_val[wa] = 1'b1;
    end
  endtask

  task automatic cyc(input logic [3:0] f, input logic s, input logic [7:0] d,
                     input int wa, input logic [2:0] en, input logic [23:0] bus,
                     input logic acc, input int ra);
    exp_t e;
    fsm = f; sin = s; din = d; waddr = AW'(wa); vtc_en = en;
    dvtc = bus; acc_mode = acc; raddr = AW'(ra);
    model_step(e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_ram_d", 32'(ram_d), 0);
    chk("rst_load_done", 32'(load_done), 0);
    chk("rst_sat_flag", 32'(sat_flag), 0);
    for (int a = 0; a < DEPTH; a++) begin
      raddr = AW'(a);
      @(posedge clk);
      #1 chk("rst_rd_vld", 32'(rd_vld), 0);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: outputs are presented every cycle; compare one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ram_d", 32'(ram_d), 32'(e.d));
        chk("rd_vld", 32'(rd_vld), 32'(e.v));
        chk("load_done", 32'(load_done), 32'(e.ld));
        chk("sat_flag", 32'(sat_flag), 32'(e.sf));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    @(negedge clk);
    do_reset();

    // Serial load of four words, then read back.
    cyc(4'b0010, 1, 8'h11, 0, 0, 0, 0, 0);
    cyc(4'b0010, 1, 8'h22, 0, 0, 0, 0, 0);
    cyc(4'b0010, 1, 8'h33, 0, 0, 0, 0, 0);
    cyc(4'b0010, 1, 8'h44, 0, 0, 0, 0, 0);
    chk("load_done_pulse", 32'(load_done), 1);
    for (int a = 0; a < DEPTH; a++) cyc(4'b0000, 0, 0, 0, 0, 0, 0, a);
    chk("read_word3", 32'(ram_d), 32'h44);

    // Highest enabled source wins.
    cyc(4'b0100, 0, 0, 2, 3'b111, {8'h0C, 8'h0B, 8'h0A}, 0, 2);
    cyc(4'b0000, 0, 0, 0, 0, 0, 0, 2);
    chk("src2_wins", 32'(ram_d), 32'h0C);

    // Positive and negative saturation.
    cyc(4'b0100, 0, 0, 1, 3'b001, 24'h000070, 0, 1);
    cyc(4'b0100, 0, 0, 1, 3'b001, 24'h000020, 1, 1);
    chk("sat_pos_flag", 32'(sat_flag), 1);
    cyc(4'b0000, 0, 0, 0, 0, 0, 0, 1);
    chk("sat_pos_val", 32'(ram_d), 32'h7F);
    cyc(4'b0100, 0, 0, 1, 3'b001, 24'h000090, 0, 1);
    cyc(4'b0100, 0, 0, 1, 3'b001, 24'h0000E0, 1, 1);
    chk("sat_neg_flag", 32'(sat_flag), 1);
    cyc(4'b0000, 0, 0, 0, 0, 0, 0, 1);
    chk("sat_neg_val", 32'(ram_d), 32'h81);

    // Load beats update; same-cycle read returns old data.
    cyc(4'b0110, 1, 8'h55, 0, 3'b001, 24'h000077, 0, 0);
    chk("rbw_old", 32'(ram_d), 32'h11);
    cyc(4'b0010, 1, 8'h66, 0, 0, 0, 0, 0);
    chk("load_wins", 32'(ram_d), 32'h55);
    cyc(4'b0000, 0, 0, 0, 0, 0, 0, 1);
    chk("lptr_advanced", 32'(ram_d), 32'h66);

    // Reset mid-load, then a full reload from word 0.
    cyc(4'b0010, 1, 8'hA1, 0, 0, 0, 0, 0);
    cyc(4'b0010, 1, 8'hA2, 0, 0, 0, 0, 0);
    do_reset();
    cyc(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_vld", 32'(rd_vld), 0);
    for (int i = 0; i < DEPTH; i++) cyc(4'b0010, 1, 8'(8'hB0 + i), 0, 0, 0, 0, 0);
    chk("reload_done", 32'(load_done), 1);
    cyc(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    chk("reload_word0", 32'(ram_d), 32'hB0);

    // No enables: no write, no flag. Dropped load phase restarts at word 0.
    cyc(4'b0100, 0, 0, 3, 3'b000, 24'h7F7F7F, 1, 3);
    chk("noen_flag", 32'(sat_flag), 0);
    cyc(4'b0010, 1, 8'hC1, 0, 0, 0, 0, 0);
    cyc(4'b0010, 1, 8'hC2, 0, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0, 0, 0, 3);
    chk("noen_mem", 32'(ram_d), 32'hB3);
    cyc(4'b0010, 1, 8'hC3, 0, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    chk("restart_word0", 32'(ram_d), 32'hC3);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom),
          $urandom_range(0, DEPTH - 1), 3'($urandom_range(0, 7)), 24'($urandom),
          1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1));
    end

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
